// File: rtl/switch_event_arbiter_pkg.sv
// rtl/switch_event_arbiter_pkg.sv - shared types and limits for the switch event arbiter
package switch_event_arbiter_pkg;

  localparam int MIN_SWITCHES     = 2;
  localparam int MAX_SWITCHES     = 8;
  localparam int NUM_SWITCHES_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/switch_event_arbiter_if.sv
// rtl/switch_event_arbiter_if.sv - valid/ready event channel towards the shared consumer
interface switch_event_arbiter_if #(
  parameter int ID_WIDTH = 2
);
  logic                event_valid;
  logic [ID_WIDTH-1:0] event_id;
  logic                event_ready;

  modport master (output event_valid, output event_id, input event_ready);
  modport slave  (input event_valid, input event_id, output event_ready);
endinterface

// File: rtl/switch_event_arbiter_rr_priority_picker.sv
// rtl/switch_event_arbiter_rr_priority_picker.sv - picks the first request at or above ptr, wrapping
module rr_priority_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         any_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    int j;
    any_o = 1'b0;
    idx_o = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx_o = j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/switch_event_arbiter.sv
// rtl/switch_event_arbiter.sv - release-edge capture, pending flags and round-robin event offer
module switch_event_arbiter
  import switch_event_arbiter_pkg::*;
#(
  parameter int NUM_SWITCHES = NUM_SWITCHES_DEF
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  switch_event_arbiter_if.master  evt,
  output logic [NUM_SWITCHES-1:0] o_Pending,
  output logic                    o_Overrun,
  input  logic                    i_Overrun_Clr,
  output logic [NUM_SWITCHES-1:0] o_LED
);

  localparam int ID_WIDTH = $clog2(NUM_SWITCHES);

  if (NUM_SWITCHES < MIN_SWITCHES || NUM_SWITCHES > MAX_SWITCHES) begin : g_bad_num_switches
    $error("switch_event_arbiter: NUM_SWITCHES out of range");
  end

  state_e                  state_q, state_d;
  logic [NUM_SWITCHES-1:0] prev_q, pending_q, pending_d, led_q, led_d;
  logic [NUM_SWITCHES-1:0] rel, grant;
  logic                    overrun_q, overrun_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d, id_q, id_d, pick_idx;
  logic                    pick_any;

  rr_priority_picker #(.N(NUM_SWITCHES), .W(ID_WIDTH)) u_picker (
    .req_i (pending_q),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    led_d    = led_q;
    grant    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          id_d    = pick_idx;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt.event_ready) begin
          grant[id_q]  = 1'b1;
          led_d[id_q]  = ~led_q[id_q];
          rr_ptr_d     = (id_q == ID_WIDTH'(NUM_SWITCHES - 1)) ? '0 : id_q + ID_WIDTH'(1);
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh release always survives, even when its predecessor is granted this cycle.
    rel       = prev_q & ~i_Switch;
    pending_d = rel | (pending_q & ~grant);
    overrun_d = (|(rel & pending_q & ~grant)) | (overrun_q & ~i_Overrun_Clr);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      led_q     <= '0;
      overrun_q <= 1'b0;
      rr_ptr_q  <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= i_Switch;
      pending_q <= pending_d;
      led_q     <= led_d;
      overrun_q <= overrun_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
    end
  end

  assign evt.event_valid = (state_q == ST_OFFER);
  assign evt.event_id    = id_q;
  assign o_Pending       = pending_q;
  assign o_Overrun       = overrun_q;
  assign o_LED           = led_q;

endmodule

// File: tb/tb_switch_event_arbiter.sv
// tb/tb_switch_event_arbiter.sv - directed and randomized checks against a behavioural event model
module tb_switch_event_arbiter;

  localparam int N = 4;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] sw;
  logic         clr;
  logic [N-1:0] pend;
  logic [N-1:0] led;
  logic         ovr;

  always #5 clk = ~clk;

  switch_event_arbiter_if #(.ID_WIDTH(W)) evt ();

  switch_event_arbiter #(.NUM_SWITCHES(N)) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Switch      (sw),
    .evt           (evt),
    .o_Pending     (pend),
    .o_Overrun     (ovr),
    .i_Overrun_Clr (clr),
    .o_LED         (led)
  );

  int checks   = 0;
  int failures = 0;

  bit [N-1:0] m_prev, m_pend, m_led;
  bit         m_ovr, m_offer;
  int         m_ptr, m_id;
  int         granted_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model by the spec rules, compare after the edge.
  task automatic cyc(input logic [N-1:0] s, input logic r, input logic c, input logic rn);
    bit [N-1:0] np, nl;
    bit         no, noff, drop, found;
    int         nptr, nid;
    sw = s; evt.event_ready = r; clr = c; rst_n = rn;
    if (rn && evt.event_valid && r) granted_q.push_back(int'(evt.event_id));
    np = '0; nl = m_led; no = 1'b0; noff = m_offer; nptr = m_ptr; nid = m_id; drop = 1'b0;
    if (!rn) begin
      nl = '0; noff = 1'b0; nptr = 0; nid = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        bit rel_i, g_i;
        rel_i = m_prev[i] && !s[i];
        g_i   = m_offer && r && (m_id == i);
        if (rel_i && m_pend[i] && !g_i) drop = 1'b1;
        np[i] = rel_i || (m_pend[i] && !g_i);
      end
      no = drop || (m_ovr && !c);
      if (m_offer && r) begin
        nl[m_id] = ~nl[m_id];
        nptr = (m_id + 1) % N;
        noff = 1'b0;
      end else if (!m_offer && m_pend != '0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && m_pend[(m_ptr + k) % N]) begin
            found = 1'b1;
            nid = (m_ptr + k) % N;
          end
        end
        noff = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_prev  = rn ? s : '0;
    m_pend  = np; m_led = nl; m_ovr = no; m_offer = noff; m_ptr = nptr; m_id = nid;
    chk("valid",   32'(evt.event_valid), 32'(m_offer));
    chk("id",      32'(evt.event_id),    32'(m_id));
    chk("pending", 32'(pend),            32'(m_pend));
    chk("overrun", 32'(ovr),             32'(m_ovr));
    chk("led",     32'(led),             32'(m_led));
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] rs;
    sw = 4'b1111; evt.event_ready = 1'b0; clr = 1'b0; rst_n = 1'b0;
    m_prev = '0; m_pend = '0; m_led = '0; m_ovr = 1'b0; m_offer = 1'b0; m_ptr = 0; m_id = 0;
    @(negedge clk);

    // Reset with switches held high, then no spurious event.
    repeat (3) cyc(4'b1111, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", 32'(evt.event_valid), 32'd0);
    chk("rst_pend",  32'(pend), 32'd0);
    chk("rst_led",   32'(led),  32'd0);
    chk("rst_ovr",   32'(ovr),  32'd0);
    chk("rst_id",    32'(evt.event_id), 32'd0);
    repeat (4) cyc(4'b1111, 1'b1, 1'b0, 1'b1);
    chk("hi_valid", 32'(evt.event_valid), 32'd0);
    chk("hi_pend",  32'(pend), 32'd0);

    // Single event on switch 0.
    cyc(4'b1110, 1'b1, 1'b0, 1'b1);
    chk("s2_pend1",  32'(pend), 32'b0001);
    chk("s2_valid1", 32'(evt.event_valid), 32'd0);
    cyc(4'b1110, 1'b1, 1'b0, 1'b1);
    chk("s2_valid2", 32'(evt.event_valid), 32'd1);
    chk("s2_id2",    32'(evt.event_id), 32'd0);
    cyc(4'b1110, 1'b1, 1'b0, 1'b1);
    chk("s2_valid3", 32'(evt.event_valid), 32'd0);
    chk("s2_led3",   32'(led), 32'b0001);
    chk("s2_pend3",  32'(pend), 32'd0);

    // Round robin over simultaneous releases of switches 1..3.
    cyc(4'b1111, 1'b1, 1'b0, 1'b1);
    granted_q.delete();
    cyc(4'b0001, 1'b1, 1'b0, 1'b1);
    repeat (7) cyc(4'b0001, 1'b1, 1'b0, 1'b1);
    chk("rr_count", 32'(granted_q.size()), 32'd3);
    if (granted_q.size() == 3) begin
      chk("rr_first",  32'(granted_q[0]), 32'd1);
      chk("rr_second", 32'(granted_q[1]), 32'd2);
      chk("rr_third",  32'(granted_q[2]), 32'd3);
    end
    cyc(4'b1111, 1'b1, 1'b0, 1'b1);
    cyc(4'b1101, 1'b1, 1'b0, 1'b1);
    cyc(4'b0101, 1'b1, 1'b0, 1'b1);
    repeat (6) cyc(4'b0101, 1'b1, 1'b0, 1'b1);

    // Backpressure on switch 2.
    cyc(4'b1111, 1'b0, 1'b0, 1'b1);
    cyc(4'b1011, 1'b0, 1'b0, 1'b1);
    repeat (10) cyc(4'b1011, 1'b0, 1'b0, 1'b1);
    chk("bp_valid", 32'(evt.event_valid), 32'd1);
    chk("bp_id",    32'(evt.event_id), 32'd2);
    rs = led;
    cyc(4'b1011, 1'b1, 1'b0, 1'b1);
    chk("bp_led", 32'(led), 32'(rs ^ 4'b0100));
    cyc(4'b1011, 1'b1, 1'b0, 1'b1);
    chk("bp_once", 32'(evt.event_valid), 32'd0);

    // Overrun, clear, and clear coincident with a new drop.
    cyc(4'b1111, 1'b0, 1'b0, 1'b1);
    cyc(4'b1110, 1'b0, 1'b0, 1'b1);
    cyc(4'b1111, 1'b0, 1'b0, 1'b1);
    cyc(4'b1110, 1'b0, 1'b0, 1'b1);
    chk("ov_set", 32'(ovr), 32'd1);
    rs = led;
    cyc(4'b1110, 1'b1, 1'b0, 1'b1);
    chk("ov_led", 32'(led), 32'(rs ^ 4'b0001));
    repeat (2) cyc(4'b1110, 1'b1, 1'b0, 1'b1);
    chk("ov_single", 32'(evt.event_valid), 32'd0);
    cyc(4'b1110, 1'b0, 1'b1, 1'b1);
    chk("ov_clr", 32'(ovr), 32'd0);
    cyc(4'b1111, 1'b0, 1'b0, 1'b1);
    cyc(4'b1110, 1'b0, 1'b0, 1'b1);
    cyc(4'b1111, 1'b0, 1'b0, 1'b1);
    cyc(4'b1110, 1'b0, 1'b1, 1'b1);
    chk("ov_set_wins", 32'(ovr), 32'd1);
    repeat (3) cyc(4'b1110, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of an offer; rr pointer must restart at 0.
    cyc(4'b1111, 1'b1, 1'b0, 1'b1);
    cyc(4'b1101, 1'b0, 1'b0, 1'b1);
    cyc(4'b1101, 1'b0, 1'b0, 1'b1);
    chk("mr_valid", 32'(evt.event_valid), 32'd1);
    chk("mr_id",    32'(evt.event_id), 32'd1);
    cyc(4'b1101, 1'b0, 1'b0, 1'b0);
    chk("mr_valid0", 32'(evt.event_valid), 32'd0);
    chk("mr_pend0",  32'(pend), 32'd0);
    chk("mr_led0",   32'(led), 32'd0);
    cyc(4'b1111, 1'b1, 1'b0, 1'b1);
    cyc(4'b1010, 1'b0, 1'b0, 1'b1);
    cyc(4'b1010, 1'b0, 1'b0, 1'b1);
    chk("mr_ptr0", 32'(evt.event_id), 32'd0);

    // Randomized traffic against the model.
    rs = sw;
    repeat (400) begin
      rs = rs ^ N'($urandom & $urandom);
      cyc(rs, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 199) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
